qs_uc_trace: RTL and testbench
==============================

# qs_uc_trace

Parametrised micro-code trace capture unit for the quicksort engine's sort core. It samples the commit, register-file writeback and flag-update probe streams each cycle and packs any activity into a time-stamped entry. Entries go into a circular buffer of configurable depth, which the bench or a debug port drains over a valid/ready interface. Capture is armed and stopped by control inputs, and an optional PC trigger is available. When the buffer is full, events are dropped and counted, and the next accepted entry carries a gap marker.

## Interface

- DEPTH, 16, trace buffer entries; power of two, ≥ 2
- CYCLE_W, 32, width of the internal cycle stamp counter
- DROP_W, 16, width of the saturating drop counter

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_en  in  1  capture enable; 1 arms the unit, 0 stops capture
- cfg_trig_pc  in  qs_srt_pkg::pc_t  trigger PC (used only with QS_UC_TRACE_TRIGGER_EN)
- uc_inst_commit  in  1  instruction commit strobe
- uc_inst  in  qs_srt_pkg::inst_t  committed instruction
- uc_inst_pc  in  qs_srt_pkg::pc_t  committed PC
- uc_rf_wen  in  1  register-file write strobe
- uc_rf_wa  in  qs_srt_pkg::reg_t  write address
- uc_rf_wdata  in  qs_pkg::w_t  write data
- uc_flags_en  in  1  flag update strobe
- uc_flags_c / uc_flags_n / uc_flags_z  in  1 each  flag values
- trc_vld_r  out  1  head entry valid
- trc_rdy  in  1  consumer accepts head entry
- trc_ent_r  out  qs_uc_trace_pkg::ent_t  head entry
- trc_drop_cnt_r  out  DROP_W  dropped-event count, saturating
- trc_state_r  out  qs_uc_trace_pkg::state_t  capture state

## Operation

- Event: any of uc_inst_commit, uc_rf_wen or uc_flags_en is high while the state is CAP. One event produces one entry.
- Entry fields:
  - stamp: cycle counter value
  - per-stream valid bits: cv, wv, fv
  - pc, inst, wa, wdata, c, n, z
  - gap
- Fields belonging to an invalid stream are zeroed.
- Cycle counter: free-running from reset, wraps modulo 2^CYCLE_W. Stamp is the counter value in the event cycle.
- States:
  - IDLE → ARM when cfg_en=1.
  - ARM → CAP on the trigger condition (see Configuration).
  - CAP → IDLE when cfg_en=0.
  - ARM → IDLE when cfg_en=0.
- Draining is independent of state. Entries remain drainable in IDLE.
- Full with an event and no pop: the event is dropped, trc_drop_cnt_r increments (saturating at 2^DROP_W−1), and a sticky gap flag is set. The next accepted entry has gap=1, which clears the sticky flag.
- Full with an event and a pop in the same cycle: the push is accepted, with no drop.
- Empty with push and pop in the same cycle: no pop is possible because trc_vld_r=0. The push is accepted.
- A pop occurs on trc_vld_r & trc_rdy. trc_ent_r advances to the next entry on the following cycle.
- Pointers wrap modulo DEPTH. full/empty are distinguished by an extra pointer bit.
- Re-arming from IDLE does not clear the buffer or the drop counter. Only rst clears them.

## Timing

- Reset values:
  - trc_vld_r=0, trc_ent_r=0, trc_drop_cnt_r=0, trc_state_r=IDLE
  - cycle counter=0, pointers=0, gap flag=0
- Event in cycle N into an empty buffer: trc_vld_r=1 and trc_ent_r valid in cycle N+1 (latency 1).
- Pop in cycle N: trc_ent_r and trc_vld_r reflect the new head in cycle N+1. Back-to-back pops sustain 1 entry/cycle.
- State transitions take effect the cycle after the condition. The triggering commit itself is captured, because the trigger compare is against the same-cycle PC and the capture gate uses the next state.
- rst asserted mid-capture: the next cycle shows reset values, and in-flight entries are discarded.
- Outputs are flop-driven. No combinational path runs from trc_rdy to trc_vld_r.

## Configuration

- QS_UC_TRACE_TRIGGER_EN defined: ARM→CAP occurs when uc_inst_commit=1 and uc_inst_pc==cfg_trig_pc.
- Undefined:
  - ARM→CAP occurs unconditionally on the cycle after entering ARM.
  - cfg_trig_pc is ignored.
  - The comparator is not built.

## Structure

- Package qs_uc_trace_pkg holds:
  - ent_t, the packed entry struct
  - state_t enum {IDLE, ARM, CAP}
  - a localparam for the entry width
- Sub-module qs_uc_trace_fifo: DEPTH×ent_t circular buffer with push/pop, full/empty and registered head output.
- Top level holds the state machine, cycle counter, event packer, gap and drop logic.

## Test plan

- Reset, then cfg_en=1 with commits at PC 0x004 and 0x008 in consecutive cycles, trc_rdy=1: two entries appear with cv=1, stamps differing by 1, gap=0.
- Same cycle uc_inst_commit=1, uc_rf_wen=1 (wa=3, wdata=0x55), uc_flags_en=1 (z=1): a single entry appears with cv=wv=fv=1, wa=3, wdata=0x55, z=1.
- DEPTH=4, trc_rdy=0, 6 events, then drain: 4 entries, trc_drop_cnt_r=2. The next captured event has gap=1; the one after has gap=0.
- Full buffer, event and pop in the same cycle: trc_drop_cnt_r unchanged and occupancy stays 4.
- With QS_UC_TRACE_TRIGGER_EN, cfg_trig_pc=0x010, commits at 0x00C, 0x010, 0x014: exactly 2 entries (0x010, 0x014), state ARM→CAP.
- rst mid-capture with 3 entries buffered: the next cycle shows trc_vld_r=0, drop count 0, state IDLE.

Source files
------------

// File: rtl/qs_pkg.sv
// Shared datapath types for the quicksort engine.
package qs_pkg;
   typedef logic [15:0] w_t;
endpackage

// File: rtl/qs_srt_pkg.sv
// Sort-core micro-code types: program counter, instruction word, register index.
package qs_srt_pkg;
   typedef logic [11:0] pc_t;
   typedef logic [15:0] inst_t;
   typedef logic [3:0]  reg_t;
endpackage

// File: rtl/qs_uc_trace_pkg.sv
// Types shared by the micro-code trace unit: entry layout and capture state.
package qs_uc_trace_pkg;
   localparam int STAMP_W = 32;

   typedef struct packed {
      logic [STAMP_W-1:0] stamp;
      logic               cv;
      logic               wv;
      logic               fv;
      qs_srt_pkg::pc_t    pc;
      qs_srt_pkg::inst_t  inst;
      qs_srt_pkg::reg_t   wa;
      qs_pkg::w_t         wdata;
      logic               c;
      logic               n;
      logic               z;
      logic               gap;
   } ent_t;

   localparam int ENT_W = $bits(ent_t);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      CAP  = 2'd2
   } state_t;
endpackage

// File: rtl/qs_uc_trace_fifo.sv
// Circular trace buffer with an extra pointer bit for full/empty and a
// registered head entry, so vld/head never depend combinationally on pop.
module qs_uc_trace_fifo
   import qs_uc_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  ent_t push_ent,
   input  logic pop,
   output logic push_acc,
   output logic vld_r,
   output ent_t head_r
);
   localparam int AW = $clog2(DEPTH);

   ent_t           mem [DEPTH];
   logic [AW:0]    wr_ptr_r;
   logic [AW:0]    rd_ptr_r;
   logic [AW:0]    wr_ptr_nxt;
   logic [AW:0]    rd_ptr_nxt;
   logic           full;
   logic           pop_ok;
   logic           empty_nxt;

   assign full       = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
   assign pop_ok     = pop & vld_r;
   // A pop frees the slot the push needs, so full+pop still accepts.
   assign push_acc   = push & (~full | pop_ok);
   assign wr_ptr_nxt = wr_ptr_r + {{AW{1'b0}}, push_acc};
   assign rd_ptr_nxt = rd_ptr_r + {{AW{1'b0}}, pop_ok};
   assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr_r[AW-1:0]] <= push_ent;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         vld_r    <= 1'b0;
         head_r   <= '0;
      end else begin
         wr_ptr_r <= wr_ptr_nxt;
         rd_ptr_r <= rd_ptr_nxt;
         vld_r    <= ~empty_nxt;
         // The incoming entry becomes head only when the buffer drains to it.
         if (empty_nxt) begin
            head_r <= '0;
         end else if (push_acc && (wr_ptr_r[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
            head_r <= push_ent;
         end else begin
            head_r <= mem[rd_ptr_nxt[AW-1:0]];
         end
      end
   end
endmodule

// File: rtl/qs_uc_trace.sv
// Micro-code trace capture: packs commit/writeback/flag probes into stamped
// entries. Define QS_UC_TRACE_TRIGGER_EN to gate capture start on a PC match.
module qs_uc_trace
   import qs_uc_trace_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int CYCLE_W = 32,
   parameter int DROP_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_en,
   input  qs_srt_pkg::pc_t    cfg_trig_pc,
   input  logic               uc_inst_commit,
   input  qs_srt_pkg::inst_t  uc_inst,
   input  qs_srt_pkg::pc_t    uc_inst_pc,
   input  logic               uc_rf_wen,
   input  qs_srt_pkg::reg_t   uc_rf_wa,
   input  qs_pkg::w_t         uc_rf_wdata,
   input  logic               uc_flags_en,
   input  logic               uc_flags_c,
   input  logic               uc_flags_n,
   input  logic               uc_flags_z,
   output logic               trc_vld_r,
   input  logic               trc_rdy,
   output ent_t               trc_ent_r,
   output logic [DROP_W-1:0]  trc_drop_cnt_r,
   output state_t             trc_state_r
);
   // trc_vld_r/trc_rdy: the head entry transfers in every cycle where both
   // are high; trc_vld_r is a flop and never waits on trc_rdy.
   logic [CYCLE_W-1:0] cyc_r;
   state_t             state_nxt;
   logic               trig_hit;
   logic               evt;
   logic               push_acc;
   logic               gap_r;
   ent_t               evt_ent;

`ifdef QS_UC_TRACE_TRIGGER_EN
   assign trig_hit = uc_inst_commit && (uc_inst_pc == cfg_trig_pc);
`else
   logic unused_trig_pc;
   assign unused_trig_pc = ^cfg_trig_pc;
   assign trig_hit       = 1'b1;
`endif

   always_comb begin
      state_nxt = trc_state_r;
      case (trc_state_r)
         IDLE:    if (cfg_en) state_nxt = ARM;
         ARM:     if (!cfg_en) state_nxt = IDLE; else if (trig_hit) state_nxt = CAP;
         CAP:     if (!cfg_en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Gating on the next state lets the triggering commit land in the buffer.
   assign evt = (uc_inst_commit | uc_rf_wen | uc_flags_en) && (state_nxt == CAP);

   always_comb begin
      evt_ent       = '0;
      evt_ent.stamp = STAMP_W'(cyc_r);
      evt_ent.gap   = gap_r;
      if (uc_inst_commit) begin
         evt_ent.cv   = 1'b1;
         evt_ent.pc   = uc_inst_pc;
         evt_ent.inst = uc_inst;
      end
      if (uc_rf_wen) begin
         evt_ent.wv    = 1'b1;
         evt_ent.wa    = uc_rf_wa;
         evt_ent.wdata = uc_rf_wdata;
      end
      if (uc_flags_en) begin
         evt_ent.fv = 1'b1;
         evt_ent.c  = uc_flags_c;
         evt_ent.n  = uc_flags_n;
         evt_ent.z  = uc_flags_z;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_r          <= '0;
         trc_state_r    <= IDLE;
         trc_drop_cnt_r <= '0;
         gap_r          <= 1'b0;
      end else begin
         cyc_r       <= cyc_r + CYCLE_W'(1);
         trc_state_r <= state_nxt;
         if (evt && !push_acc) begin
            gap_r <= 1'b1;
            if (trc_drop_cnt_r != '1) begin
               trc_drop_cnt_r <= trc_drop_cnt_r + DROP_W'(1);
            end
         end else if (push_acc) begin
            gap_r <= 1'b0;
         end
      end
   end

   qs_uc_trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (evt),
      .push_ent (evt_ent),
      .pop      (trc_rdy),
      .push_acc (push_acc),
      .vld_r    (trc_vld_r),
      .head_r   (trc_ent_r)
   );
endmodule

// File: tb/tb_qs_uc_trace.sv
// Bench for qs_uc_trace: directed table, corner sequences and a randomized
// run checked against a queue-based model of the trace buffer.
module tb_qs_uc_trace;
   import qs_uc_trace_pkg::*;

   localparam int DEPTH   = 4;
   localparam int CYCLE_W = 32;
   localparam int DROP_W  = 3;

   logic               clk;
   logic               rst;
   logic               cfg_en;
   logic [11:0]        cfg_trig_pc;
   logic               uc_inst_commit;
   logic [15:0]        uc_inst;
   logic [11:0]        uc_inst_pc;
   logic               uc_rf_wen;
   logic [3:0]         uc_rf_wa;
   logic [15:0]        uc_rf_wdata;
   logic               uc_flags_en;
   logic               uc_flags_c;
   logic               uc_flags_n;
   logic               uc_flags_z;
   logic               trc_vld_r;
   logic               trc_rdy;
   ent_t               trc_ent_r;
   logic [DROP_W-1:0]  trc_drop_cnt_r;
   state_t             trc_state_r;

   qs_uc_trace #(
      .DEPTH   (DEPTH),
      .CYCLE_W (CYCLE_W),
      .DROP_W  (DROP_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_en         (cfg_en),
      .cfg_trig_pc    (cfg_trig_pc),
      .uc_inst_commit (uc_inst_commit),
      .uc_inst        (uc_inst),
      .uc_inst_pc     (uc_inst_pc),
      .uc_rf_wen      (uc_rf_wen),
      .uc_rf_wa       (uc_rf_wa),
      .uc_rf_wdata    (uc_rf_wdata),
      .uc_flags_en    (uc_flags_en),
      .uc_flags_c     (uc_flags_c),
      .uc_flags_n     (uc_flags_n),
      .uc_flags_z     (uc_flags_z),
      .trc_vld_r      (trc_vld_r),
      .trc_rdy        (trc_rdy),
      .trc_ent_r      (trc_ent_r),
      .trc_drop_cnt_r (trc_drop_cnt_r),
      .trc_state_r    (trc_state_r)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [ENT_W-1:0] exp_q[$];
   int               m_drop;
   bit               m_gap;
   state_t           m_state;
   logic [31:0]      m_cyc;
   int               checks;
   int               errors;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ent_t model_ent(input bit gap);
      ent_t e;
      e       = '0;
      e.stamp = m_cyc;
      e.gap   = gap;
      if (uc_inst_commit) begin
         e.cv = 1'b1; e.pc = uc_inst_pc; e.inst = uc_inst;
      end
      if (uc_rf_wen) begin
         e.wv = 1'b1; e.wa = uc_rf_wa; e.wdata = uc_rf_wdata;
      end
      if (uc_flags_en) begin
         e.fv = 1'b1; e.c = uc_flags_c; e.n = uc_flags_n; e.z = uc_flags_z;
      end
      return e;
   endfunction

   // One clock with the current inputs; the model follows the capture rules
   // and the buffer is a bounded queue.
   task automatic cycle();
      state_t nxt;
      bit     trig_ok;
      bit     pop;
      bit     evt;
      ent_t   e;
`ifdef QS_UC_TRACE_TRIGGER_EN
      trig_ok = uc_inst_commit && (uc_inst_pc == cfg_trig_pc);
`else
      trig_ok = 1'b1;
`endif
      nxt = m_state;
      if (!cfg_en) nxt = IDLE;
      else if (m_state == IDLE) nxt = ARM;
      else if (m_state == ARM && trig_ok) nxt = CAP;
      evt = (nxt == CAP) && (uc_inst_commit || uc_rf_wen || uc_flags_en);
      pop = (exp_q.size() != 0) && trc_rdy;
      e   = model_ent(m_gap);
      @(posedge clk);
      #1;
      if (pop) void'(exp_q.pop_front());
      if (evt) begin
         if (exp_q.size() < DEPTH) begin
            exp_q.push_back(e);
            m_gap = 1'b0;
         end else begin
            if (m_drop < (1 << DROP_W) - 1) m_drop++;
            m_gap = 1'b1;
         end
      end
      m_state = nxt;
      m_cyc   = m_cyc + 32'd1;
      check("vld", 128'(trc_vld_r), 128'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("head", 128'(trc_ent_r), 128'(exp_q[0]));
      check("drop", 128'(trc_drop_cnt_r), 128'(m_drop));
      check("state", 128'(trc_state_r), 128'(m_state));
   endtask

   // driver tasks
   task automatic clear_in();
      uc_inst_commit = 1'b0; uc_inst = 16'h0; uc_inst_pc = 12'h0;
      uc_rf_wen = 1'b0; uc_rf_wa = 4'h0; uc_rf_wdata = 16'h0;
      uc_flags_en = 1'b0; uc_flags_c = 1'b0; uc_flags_n = 1'b0; uc_flags_z = 1'b0;
   endtask

   task automatic commit_at(input logic [11:0] pc);
      clear_in();
      uc_inst_commit = 1'b1;
      uc_inst_pc     = pc;
      uc_inst        = {4'hA, pc};
   endtask

   task automatic do_reset();
      clear_in();
      cfg_en  = 1'b0;
      trc_rdy = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_drop  = 0;
      m_gap   = 1'b0;
      m_state = IDLE;
      m_cyc   = 32'd0;
      check("rst_vld", 128'(trc_vld_r), 128'(1'b0));
      check("rst_ent", 128'(trc_ent_r), 128'(0));
      check("rst_drop", 128'(trc_drop_cnt_r), 128'(0));
      check("rst_state", 128'(trc_state_r), 128'(IDLE));
   endtask

   task automatic drain_count(output int n);
      n = 0;
      clear_in();
      trc_rdy = 1'b1;
      for (int k = 0; k < 2 * DEPTH + 2; k++) begin
         if (!trc_vld_r) break;
         n++;
         cycle();
      end
      trc_rdy = 1'b0;
   endtask

   typedef struct {
      bit          commit;
      logic [11:0] pc;
      logic [15:0] inst;
      bit          wen;
      logic [3:0]  wa;
      logic [15:0] wdata;
      bit          fen, c, n, z;
      bit          rdy;
      bit          e_vld, e_cv, e_wv, e_fv;
      logic [11:0] e_pc;
      logic [3:0]  e_wa;
      logic [15:0] e_wdata;
      bit          e_c, e_n, e_z;
   } vec_t;

   vec_t        tbl[6];
   int          n;
   logic [31:0] s0;

   initial begin
      checks = 0;
      errors = 0;
      cfg_trig_pc = 12'h010;
      clear_in();
      cfg_en  = 1'b0;
      trc_rdy = 1'b0;
      rst     = 1'b0;

      tbl[0] = '{1'b1, 12'h004, 16'h1111, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b0, 12'h004, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 12'h008, 16'h2222, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b0, 12'h008, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 12'h00C, 16'h3333, 1'b1, 4'h3, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b1, 12'h00C, 4'h3, 16'h0055, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 12'h0FF, 16'hFFFF, 1'b1, 4'h5, 16'h00AA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 4'h5, 16'h00AA, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 12'h000, 16'h0000, 1'b0, 4'hF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 12'h000, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};

      do_reset();

      // arm; the commit at the trigger PC moves ARM to CAP in either build
      cfg_en = 1'b1;
      cycle();
      check("arm_state", 128'(trc_state_r), 128'(ARM));
      trc_rdy = 1'b1;
      commit_at(12'h010);
      cycle();
      check("cap_state", 128'(trc_state_r), 128'(CAP));

      // directed table
      for (int i = 0; i < 6; i++) begin
         uc_inst_commit = tbl[i].commit; uc_inst_pc = tbl[i].pc; uc_inst = tbl[i].inst;
         uc_rf_wen = tbl[i].wen; uc_rf_wa = tbl[i].wa; uc_rf_wdata = tbl[i].wdata;
         uc_flags_en = tbl[i].fen; uc_flags_c = tbl[i].c; uc_flags_n = tbl[i].n;
         uc_flags_z = tbl[i].z; trc_rdy = tbl[i].rdy;
         cycle();
         check("tbl_vld", 128'(trc_vld_r), 128'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            check("tbl_cv", 128'(trc_ent_r.cv), 128'(tbl[i].e_cv));
            check("tbl_wv", 128'(trc_ent_r.wv), 128'(tbl[i].e_wv));
            check("tbl_fv", 128'(trc_ent_r.fv), 128'(tbl[i].e_fv));
            check("tbl_pc", 128'(trc_ent_r.pc), 128'(tbl[i].e_pc));
            check("tbl_wa", 128'(trc_ent_r.wa), 128'(tbl[i].e_wa));
            check("tbl_wdata", 128'(trc_ent_r.wdata), 128'(tbl[i].e_wdata));
            check("tbl_cnz", 128'({trc_ent_r.c, trc_ent_r.n, trc_ent_r.z}),
                  128'({tbl[i].e_c, tbl[i].e_n, tbl[i].e_z}));
            check("tbl_gap", 128'(trc_ent_r.gap), 128'(1'b0));
         end
         if (i == 0) s0 = trc_ent_r.stamp;
         if (i == 1) check("stamp_delta", 128'(trc_ent_r.stamp - s0), 128'(32'd1));
      end

      // overflow: 6 events into 4 slots
      trc_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         commit_at(12'h100 + 12'(4 * i));
         cycle();
      end
      check("ovf_drop", 128'(trc_drop_cnt_r), 128'(2));
      drain_count(n);
      check("ovf_drained", 128'(n), 128'(4));
      commit_at(12'h200);
      cycle();
      check("gap_set", 128'(trc_ent_r.gap), 128'(1'b1));
      trc_rdy = 1'b1;
      commit_at(12'h204);
      cycle();
      check("gap_clear", 128'(trc_ent_r.gap), 128'(1'b0));
      drain_count(n);

      // full buffer: event with a pop in the same cycle is not dropped
      for (int i = 0; i < DEPTH; i++) begin
         commit_at(12'h300 + 12'(4 * i));
         cycle();
      end
      commit_at(12'h340);
      trc_rdy = 1'b1;
      cycle();
      trc_rdy = 1'b0;
      check("fullpop_drop", 128'(trc_drop_cnt_r), 128'(2));
      drain_count(n);
      check("fullpop_occ", 128'(n), 128'(DEPTH));

      // drop counter saturates
      for (int i = 0; i < 10; i++) begin
         commit_at(12'h400 + 12'(4 * i));
         cycle();
      end
      check("drop_sat", 128'(trc_drop_cnt_r), 128'((1 << DROP_W) - 1));

      // stop and re-arm keep buffer and drop count
      cfg_en = 1'b0;
      commit_at(12'h500);
      cycle();
      check("stop_state", 128'(trc_state_r), 128'(IDLE));
      check("stop_vld", 128'(trc_vld_r), 128'(1'b1));
      cfg_en = 1'b1;
      clear_in();
      cycle();
      check("rearm_drop", 128'(trc_drop_cnt_r), 128'((1 << DROP_W) - 1));
      drain_count(n);
      check("rearm_kept", 128'(n), 128'(DEPTH));

      // trigger sequence 0x00C, 0x010, 0x014
      do_reset();
      cfg_en = 1'b1;
      cycle();
      commit_at(12'h00C);
      cycle();
`ifdef QS_UC_TRACE_TRIGGER_EN
      check("trig_wait", 128'(trc_state_r), 128'(ARM));
`else
      check("trig_wait", 128'(trc_state_r), 128'(CAP));
`endif
      commit_at(12'h010);
      cycle();
      check("trig_hit", 128'(trc_state_r), 128'(CAP));
      commit_at(12'h014);
      cycle();
`ifdef QS_UC_TRACE_TRIGGER_EN
      check("trig_first", 128'(trc_ent_r.pc), 128'(12'h010));
      drain_count(n);
      check("trig_count", 128'(n), 128'(2));
`else
      check("trig_first", 128'(trc_ent_r.pc), 128'(12'h00C));
      drain_count(n);
      check("trig_count", 128'(n), 128'(3));
`endif

      // reset mid-capture with 3 entries buffered
      for (int i = 0; i < 3; i++) begin
         commit_at(12'h600 + 12'(4 * i));
         cycle();
      end
      check("pre_rst_vld", 128'(trc_vld_r), 128'(1'b1));
      do_reset();

      // randomized run
      cfg_en = 1'b1;
      cycle();
      for (int i = 0; i < 800; i++) begin
         uc_inst_commit = ($urandom_range(0, 2) == 0);
         uc_inst_pc     = 12'h010 + 12'(4 * $urandom_range(0, 3));
         uc_inst        = 16'($urandom);
         uc_rf_wen      = ($urandom_range(0, 2) == 0);
         uc_rf_wa       = 4'($urandom);
         uc_rf_wdata    = 16'($urandom);
         uc_flags_en    = ($urandom_range(0, 2) == 0);
         uc_flags_c     = 1'($urandom);
         uc_flags_n     = 1'($urandom);
         uc_flags_z     = 1'($urandom);
         trc_rdy        = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 39) == 0) cfg_en = ~cfg_en;
         cycle();
      end
      drain_count(n);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
